cnn_window_gen: RTL and testbench

CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

---
 rtl/cnn_window_gen_pkg.sv | 36 +++
 rtl/CNNConfig.vh | 14 +
 rtl/cnn_window_gen_line_buffer.sv | 31 +++
 rtl/cnn_window_gen.sv | 199 +++++++++++++++++++
 tb/tb_cnn_window_gen.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_window_gen_pkg.sv
// Package for the CNN window generator: derived sizes, kernel-mode enum and
// the kernel-encoding decoder shared by the top level and the bench.
`include "CNNConfig.vh"

package cnn_window_gen_pkg;

    localparam int PIX_W     = 32;
    localparam int WIN_ELEMS = `WINDOW_SIZE;
    localparam int WIN_W     = WIN_ELEMS * PIX_W;
    localparam int KSEL_W    = `KERNEL_SIZE;
    localparam int DIM_W     = `IMG_DIM_WIDTH;
    localparam int MAX_W     = `MAX_IMG_WIDTH;
    localparam int ADDR_W    = $clog2(MAX_W);

    typedef enum logic [1:0] {
        KERN_2X2 = 2'd0,
        KERN_3X3 = 2'd1,
        KERN_BAD = 2'd2
    } kernel_t;

    // Both dimensions must carry the same one-hot code; anything else is
    // treated as an unsupported kernel that produces no windows.
    function automatic kernel_t decode_kernel(input logic [KSEL_W-1:0] kh,
                                              input logic [KSEL_W-1:0] kw);
        kernel_t mode;
        if (kh == KSEL_W'(2) && kw == KSEL_W'(2)) begin
            mode = KERN_2X2;
        end else if (kh == KSEL_W'(4) && kw == KSEL_W'(4)) begin
            mode = KERN_3X3;
        end else begin
            mode = KERN_BAD;
        end
        return mode;
    endfunction

endpackage

// File: rtl/CNNConfig.vh
// Shared size configuration for the CNN window generator.
//   KERNEL_SIZE   : width of the one-hot kernel-size fields (bit1 = 2, bit2 = 3)
//   WINDOW_SIZE   : number of 32-bit elements in the largest (3x3) window
//   MAX_IMG_WIDTH : line-buffer depth, i.e. the widest supported frame
//   IMG_DIM_WIDTH : bit width of the frame dimension inputs
`ifndef CNN_CONFIG_VH
`define CNN_CONFIG_VH

`define KERNEL_SIZE   3
`define WINDOW_SIZE   9
`define MAX_IMG_WIDTH 32
`define IMG_DIM_WIDTH 6

`endif

// File: rtl/cnn_window_gen_line_buffer.sv
// One image row of pixel storage.
//   clk     : clock
//   we      : write the pixel at addr this cycle
//   addr    : column address shared by the write and read ports
//   wr_data : pixel to store
//   rd_data : pixel currently stored at addr (value before this cycle's write)
// The read is combinational so the previous row's pixel at the current column
// is available in the same cycle the new pixel is accepted and overwrites it.
`include "CNNConfig.vh"

module cnn_line_buffer
    import cnn_window_gen_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [MAX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/cnn_window_gen.sv
// CNN sliding-window generator with stride equal to the kernel size.
//   clk, rst                    : clock, asynchronous active-high reset
//   conf_refresh                : latch kernel/dimensions, restart the frame
//   kernel_height, kernel_width : one-hot kernel size (bit1 = 2, bit2 = 3)
//   img_width, img_height       : frame dimensions in pixels
//   pix_valid, pix_data         : raster-order pixel stream in
//   pix_ready                   : pixel accepted on pix_valid & pix_ready
//   window_valid, window        : completed KxK window, element (r,c) at
//                                 window[(r*K+c)*32 +: 32], unused elements 0
//   window_stall                : downstream back-pressure
//   frame_done                  : one-cycle pulse after a frame's last pixel
`include "CNNConfig.vh"

module cnn_window_gen
    import cnn_window_gen_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        conf_refresh,
    input  logic [`KERNEL_SIZE-1:0]     kernel_height,
    input  logic [`KERNEL_SIZE-1:0]     kernel_width,
    input  logic [`IMG_DIM_WIDTH-1:0]   img_width,
    input  logic [`IMG_DIM_WIDTH-1:0]   img_height,
    input  logic                        pix_valid,
    input  logic [31:0]                 pix_data,
    output logic                        pix_ready,
    output logic                        window_valid,
    output logic [`WINDOW_SIZE*32-1:0]  window,
    input  logic                        window_stall,
    output logic                        frame_done
);

    kernel_t          kernel_reg;
    logic [DIM_W-1:0] width_reg;
    logic [DIM_W-1:0] height_reg;
    logic [DIM_W-1:0] row_reg;
    logic [DIM_W-1:0] col_reg;
    // Position inside the current KxK block; a window completes when both
    // reach K-1. Trailing partial blocks never reach K-1 and are dropped.
    logic [1:0]       rmod_reg;
    logic [1:0]       cmod_reg;
    logic             window_valid_reg;
    logic [WIN_W-1:0] window_reg;
    logic             frame_done_reg;

    // Shift register of the last three columns, [row][col], col 2 newest.
    logic [PIX_W-1:0] sr_reg  [3][3];
    logic [PIX_W-1:0] sr_next [3][3];
    logic [PIX_W-1:0] new_col [3];
    logic [WIN_W-1:0] window_next;

    logic             accept;
    logic             is_k3;
    logic [1:0]       k_last;
    logic             last_col;
    logic             last_row;
    logic             win_done;

    logic [1:0]       lb_we;
    logic [PIX_W-1:0] lb_wr [2];
    logic [PIX_W-1:0] lb_rd [2];

    assign pix_ready    = ~window_stall & ~conf_refresh;
    assign accept       = pix_valid & pix_ready;
    assign is_k3        = (kernel_reg == KERN_3X3);
    assign k_last       = is_k3 ? 2'd2 : 2'd1;
    assign last_col     = (col_reg == width_reg - DIM_W'(1));
    assign last_row     = (row_reg == height_reg - DIM_W'(1));
    assign win_done     = accept && (kernel_reg != KERN_BAD) &&
                          (rmod_reg == k_last) && (cmod_reg == k_last);

    assign window_valid = window_valid_reg;
    assign window       = window_reg;
    assign frame_done   = frame_done_reg;

    // Row buffer 0 holds the previous row; buffer 1 receives what buffer 0
    // evicts, i.e. the row before that, and is only needed for 3x3.
    for (genvar gi = 0; gi < 2; gi++) begin : g_row
        if (gi == 0) begin : g_newest
            assign lb_we[gi] = accept;
            assign lb_wr[gi] = pix_data;
        end else begin : g_older
            assign lb_we[gi] = accept & is_k3;
            assign lb_wr[gi] = lb_rd[gi-1];
        end

        cnn_line_buffer u_line_buffer (
            .clk     (clk),
            .we      (lb_we[gi]),
            .addr    (col_reg[ADDR_W-1:0]),
            .wr_data (lb_wr[gi]),
            .rd_data (lb_rd[gi])
        );
    end

    // New column entering the shift register, top row first. For 2x2 only
    // rows 0..1 matter and the window is taken from columns 1..2.
    always_comb begin
        new_col[0] = is_k3 ? lb_rd[1] : lb_rd[0];
        new_col[1] = is_k3 ? lb_rd[0] : pix_data;
        new_col[2] = is_k3 ? pix_data : '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sr_next[r][c] = sr_reg[r][c];
            end
        end
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                sr_next[r][0] = sr_reg[r][1];
                sr_next[r][1] = sr_reg[r][2];
                sr_next[r][2] = new_col[r];
            end
        end
    end

    always_comb begin
        window_next = '0;
        if (is_k3) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    window_next[(r*3+c)*PIX_W +: PIX_W] = sr_next[r][c];
                end
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    window_next[(r*2+c)*PIX_W +: PIX_W] = sr_next[r][c+1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_reg       <= KERN_2X2;
            row_reg          <= '0;
            col_reg          <= '0;
            rmod_reg         <= '0;
            cmod_reg         <= '0;
            window_valid_reg <= 1'b0;
            window_reg       <= '0;
            frame_done_reg   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    sr_reg[r][c] <= '0;
                end
            end
        end else begin
            frame_done_reg <= accept && last_col && last_row;
            if (conf_refresh) begin
                kernel_reg       <= decode_kernel(kernel_height, kernel_width);
                row_reg          <= '0;
                col_reg          <= '0;
                rmod_reg         <= '0;
                cmod_reg         <= '0;
                window_valid_reg <= 1'b0;
            end else begin
                if (accept) begin
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            sr_reg[r][c] <= sr_next[r][c];
                        end
                    end
                    if (last_col) begin
                        col_reg  <= '0;
                        cmod_reg <= '0;
                        if (last_row) begin
                            row_reg  <= '0;
                            rmod_reg <= '0;
                        end else begin
                            row_reg  <= row_reg + DIM_W'(1);
                            rmod_reg <= (rmod_reg == k_last) ? 2'd0 : rmod_reg + 2'd1;
                        end
                    end else begin
                        col_reg  <= col_reg + DIM_W'(1);
                        cmod_reg <= (cmod_reg == k_last) ? 2'd0 : cmod_reg + 2'd1;
                    end
                end
                // A completing accept implies no stall, so any held window
                // is consumed in the same cycle the new one is loaded.
                if (win_done) begin
                    window_reg       <= window_next;
                    window_valid_reg <= 1'b1;
                end else if (window_valid_reg && !window_stall) begin
                    window_valid_reg <= 1'b0;
                end
            end
        end
    end

    // Frame dimensions are pure configuration: only a refresh changes them.
    always_ff @(posedge clk) begin
        if (conf_refresh) begin
            width_reg  <= img_width;
            height_reg <= img_height;
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen. Expected windows are built from a
// block-decomposition model of the frame and consumed in order whenever the
// DUT hands a window over (window_valid & ~window_stall).
module tb_cnn_window_gen;
    import cnn_window_gen_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              conf_refresh;
    logic [KSEL_W-1:0] kernel_height;
    logic [KSEL_W-1:0] kernel_width;
    logic [DIM_W-1:0]  img_width;
    logic [DIM_W-1:0]  img_height;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic              window_valid;
    logic [WIN_W-1:0]  window;
    logic              window_stall;
    logic              frame_done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [PIX_W-1:0] pix_mem [1024];
    logic [WIN_W-1:0] exp_q [$];
    logic             hold_chk = 1'b0;
    logic [WIN_W-1:0] held_win;

    cnn_window_gen dut (
        .clk           (clk),
        .rst           (rst),
        .conf_refresh  (conf_refresh),
        .kernel_height (kernel_height),
        .kernel_width  (kernel_width),
        .img_width     (img_width),
        .img_height    (img_height),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .window_valid  (window_valid),
        .window        (window),
        .window_stall  (window_stall),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: ready rule, hold-under-stall, window hand-over, frame_done count.
    always @(negedge clk) begin
        logic [WIN_W-1:0] exp_w;
        chk_val("pix_ready_rule", 32'(pix_ready), 32'(!window_stall && !conf_refresh));
        if (frame_done === 1'b1) done_cnt++;
        if (hold_chk && !rst) begin
            chk_val("stall_hold_valid", 32'(window_valid), 32'd1);
            chk_win("stall_hold_window", window, held_win);
        end
        hold_chk = !rst && (window_valid === 1'b1) && window_stall && !conf_refresh;
        held_win = window;
        if (!rst && window_valid === 1'b1 && !window_stall) begin
            chk_val("window_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                chk_win("window_data", window, exp_w);
            end
        end
    end

    task automatic fill_seq(input int n);
        for (int i = 1; i <= n; i++) pix_mem[i] = PIX_W'(i);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 1; i <= n; i++) pix_mem[i] = $urandom;
    endtask

    // Pixel (row, col) is pix_mem[row*w + col + 1]; each KxK block whose rows
    // and columns all lie inside the frame is one window, in raster order.
    task automatic push_windows(input int k, input int w, input int h, input int limit);
        int n = 0;
        for (int br = 0; br < h / k; br++) begin
            for (int bc = 0; bc < w / k; bc++) begin
                logic [WIN_W-1:0] win;
                win = '0;
                for (int r = 0; r < k; r++) begin
                    for (int c = 0; c < k; c++) begin
                        win[(r*k+c)*PIX_W +: PIX_W] = pix_mem[(br*k+r)*w + bc*k + c + 1];
                    end
                end
                if (n < limit) exp_q.push_back(win);
                n++;
            end
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic configure(input logic [KSEL_W-1:0] kh, input logic [KSEL_W-1:0] kw,
                             input int w, input int h);
        kernel_height = kh;
        kernel_width  = kw;
        img_width     = DIM_W'(w);
        img_height    = DIM_W'(h);
        conf_refresh  = 1'b1;
        @(posedge clk); #1;
        conf_refresh  = 1'b0;
    endtask

    task automatic send_pixels(input int first, input int last, input bit rnd, input bit frame_end);
        int  idx = first;
        int  guard = 0;
        bit  took;
        while (idx <= last) begin
            pix_valid    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_data     = pix_mem[idx];
            window_stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            took = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (took) idx++;
            guard++;
            if (guard > 2000) begin
                chk_val("send_timeout", 32'(idx), 32'(last + 1));
                break;
            end
        end
        pix_valid    = 1'b0;
        window_stall = 1'b0;
        if (frame_end) begin
            @(negedge clk);
            chk_val("frame_done_pulse", 32'(frame_done), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic settle(input int exp_done);
        window_stall = 1'b0;
        pix_valid    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("windows_outstanding", 32'(exp_q.size()), 32'd0);
        chk_val("frame_done_count", 32'(done_cnt), 32'(exp_done));
        exp_q.delete();
        done_cnt = 0;
    endtask

    localparam logic [KSEL_W-1:0] K2 = KSEL_W'(2);
    localparam logic [KSEL_W-1:0] K3 = KSEL_W'(4);

    initial begin
        rst           = 1'b1;
        conf_refresh  = 1'b0;
        pix_valid     = 1'b0;
        pix_data      = '0;
        window_stall  = 1'b0;
        kernel_height = K2;
        kernel_width  = K2;
        img_width     = DIM_W'(4);
        img_height    = DIM_W'(4);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_val("rst_window_valid", 32'(window_valid), 32'd0);
        chk_val("rst_frame_done", 32'(frame_done), 32'd0);
        chk_win("rst_window", window, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_val("ready_after_rst", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;

        // K=2, 4x4, pixels 1..16
        configure(K2, K2, 4, 4);
        fill_seq(16);
        push_windows(2, 4, 4, 99);
        send_pixels(1, 16, 1'b0, 1'b1);
        settle(1);

        // K=3, 6x6, pixels 1..36
        configure(K3, K3, 6, 6);
        fill_seq(36);
        push_windows(3, 6, 6, 99);
        send_pixels(1, 36, 1'b0, 1'b1);
        settle(1);

        // K=2, stall held 3 cycles while the first window is valid
        configure(K2, K2, 4, 4);
        fill_seq(16);
        push_windows(2, 4, 4, 99);
        send_pixels(1, 6, 1'b0, 1'b0);
        window_stall = 1'b1;
        pix_valid    = 1'b1;
        pix_data     = pix_mem[7];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_val("stall_pix_ready", 32'(pix_ready), 32'd0);
            chk_val("stall_window_valid", 32'(window_valid), 32'd1);
            chk_win("stall_window", window, exp_q[0]);
            @(posedge clk); #1;
        end
        window_stall = 1'b0;
        send_pixels(7, 16, 1'b0, 1'b1);
        settle(1);

        // K=2, 5x5: trailing row and column dropped
        configure(K2, K2, 5, 5);
        fill_seq(25);
        push_windows(2, 5, 5, 99);
        send_pixels(1, 25, 1'b0, 1'b1);
        settle(1);

        // rst after pixel 7, then a full frame without reconfiguration
        configure(K2, K2, 4, 4);
        fill_seq(16);
        push_windows(2, 4, 4, 1);
        send_pixels(1, 7, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_val("async_rst_valid", 32'(window_valid), 32'd0);
        chk_val("async_rst_done", 32'(frame_done), 32'd0);
        chk_win("async_rst_window", window, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        settle(0);
        push_windows(2, 4, 4, 99);
        send_pixels(1, 16, 1'b0, 1'b1);
        settle(1);

        // conf_refresh mid-frame with a window pending under stall
        configure(K2, K2, 4, 4);
        fill_seq(16);
        push_windows(2, 4, 4, 1);
        send_pixels(1, 8, 1'b0, 1'b0);
        window_stall = 1'b1;
        @(negedge clk);
        chk_val("pending_before_refresh", 32'(window_valid), 32'd1);
        @(posedge clk); #1;
        configure(K2, K2, 4, 4);
        @(negedge clk);
        chk_val("refresh_drops_valid", 32'(window_valid), 32'd0);
        @(posedge clk); #1;
        window_stall = 1'b0;
        settle(0);
        push_windows(2, 4, 4, 99);
        send_pixels(1, 16, 1'b0, 1'b1);
        settle(1);

        // Unsupported kernel encoding: pixels consumed, no windows, done pulses
        configure(KSEL_W'(1), KSEL_W'(1), 4, 4);
        fill_rand(16);
        send_pixels(1, 16, 1'b1, 1'b1);
        settle(1);

        // Randomised frames with gaps and back-pressure
        for (int f = 0; f < 8; f++) begin
            int k;
            int w;
            int h;
            k = $urandom_range(2, 3);
            w = $urandom_range(1, 10);
            h = $urandom_range(1, 10);
            configure((k == 3) ? K3 : K2, (k == 3) ? K3 : K2, w, h);
            fill_rand(w * h);
            push_windows(k, w, h, 999);
            send_pixels(1, w * h, 1'b1, 1'b1);
            settle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
